tile_instgen: RTL
=================

TILE_INSTGEN -- requirements
Module: tile_instgen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 32, CSR byte-address width.
- DATA_W, 32, CSR data and shape field width.
- FRAM_AW, 14, feature/output BRAM word-address width.
- KRAM_AW, 12, kernel BRAM word-address width.
- TILE_CH, 8, maximum output channels per instruction.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- csr_valid  in  1  command valid.
- csr_ready  out  1  high in IDLE only.
- csr_abort  in  1  synchronous abort.
- feature_baseaddr, kernel_baseaddr, output_baseaddr  in  ADDR_W each  SOC byte addresses.
- feature_width, feature_chin, feature_chout, kernel_sizeh, kernel_sizew, stride_x, stride_y, output_width, output_height  in  DATA_W each  shape fields.
- has_bias, has_relu  in  1 each  flags.
- inst_valid  out  1  instruction valid.
- inst_ready  in  1  decoder accepts.
- inst_fbase  out  FRAM_AW  feature window word address.
- inst_kbase  out  KRAM_AW  kernel tile word address.
- inst_wbbase  out  FRAM_AW  write-back word address.
- inst_wb_ch_offset  out  DATA_W  output plane size, output_width*output_height.
- inst_chout  out  DATA_W  channels in this tile.
- inst_chin, inst_fwidth, inst_ksizeh, inst_ksizew  out  DATA_W each  registered copies.
- inst_has_bias, inst_has_relu  out  1 each  registered copies.
- inst_last  out  1  final instruction of command.
- conv_complete  out  1  one-cycle done pulse.
- cfg_err  out  1  sticky bad-config flag.

Function
REQ-003 States: IDLE, INIT, EXEC, DONE, encoded in 2 bits.
REQ-004 IDLE: when csr_valid and csr_ready, capture all CSR inputs and go to INIT.
REQ-005 Byte-to-word address conversion: word address = byte address [2 +: width], giving FRAM_AW bits for feature/output and KRAM_AW bits for kernel.
REQ-006 INIT lasts exactly 1 cycle and registers:
- num_tiles = ceil(chout/TILE_CH).
- ktile_words = TILE_CH*chin*kh*kw, truncated to KRAM_AW.
- plane = output_width*output_height.
It then enters EXEC with ox=oy=t=0.
REQ-007 INIT goes to DONE instead of EXEC, setting cfg_err, if any of these is zero: output_width, output_height, chout, kh, kw, stride_x, stride_y. No instruction is issued.
REQ-008 Loop order: t innermost, then ox, then oy.
- A handshake (inst_valid & inst_ready) advances t.
- t wraps to 0 after num_tiles-1 and advances ox.
- ox wraps to 0 after output_width-1 and advances oy.
REQ-009 inst_fbase = fbase_w + oy*stride_y*feature_width + ox*stride_x, modulo 2^FRAM_AW.
REQ-010 inst_kbase = kbase_w + t*ktile_words, modulo 2^KRAM_AW.
REQ-011 inst_wbbase = obase_w + t*TILE_CH*plane + oy*output_width + ox, modulo 2^FRAM_AW.
REQ-012 inst_chout = min(TILE_CH, chout − t*TILE_CH).
REQ-013 Address terms are maintained incrementally with adders, not per-cycle multipliers. Row and tile bases are accumulated on wrap.
REQ-014 inst_valid is high in EXEC only.
- All inst_* outputs stay stable while inst_valid is high and inst_ready is low.
- Back-to-back handshakes issue one instruction per cycle with no bubble.
REQ-015 inst_last = (t==num_tiles-1) & (ox==output_width-1) & (oy==output_height-1).
- A handshake with inst_last moves to DONE.
REQ-016 DONE lasts 1 cycle, asserts conv_complete, then returns to IDLE.
REQ-017 cfg_err clears on the next accepted command.
REQ-018 csr_abort in INIT or EXEC forces IDLE on the next edge.
- No conv_complete pulse.
- Counters cleared.
- A handshake in the same cycle as abort is still counted by the decoder, but no further instructions follow.
REQ-019 csr_abort in IDLE or DONE has no effect.
REQ-020 Total instructions per command = output_width*output_height*num_tiles.

Reset
REQ-021 On rst high, asynchronously:
- state goes to IDLE.
- All counters and captured registers go to 0.
- All inst_* outputs and conv_complete go to 0.
- cfg_err goes to 0.
- csr_ready goes to 1.
REQ-022 Reset mid-EXEC discards the command. After rst falls, the first rising edge may accept a new command.

Verification
REQ-023 Bench scenario, basic single tile:
- Setup: fw=4, out 2x2, stride 1/1, kh=kw=3, chin=2, chout=8, bases 0x100/0x200/0x400, inst_ready=1.
- Required: 4 instructions with fbase 0x40,0x41,0x44,0x45 and wbbase 0x100..0x103. kbase 0x80 and wb_ch_offset 4 throughout. Last one has inst_last. conv_complete 1 cycle later.
REQ-024 Bench scenario, channel tiling:
- Setup: chout=20, TILE_CH=8, out 1x1, chin=1, kh=kw=1, bases 0.
- Required: 3 instructions with inst_chout 8,8,4, kbase 0,8,16, and wbbase 0,8,16.
REQ-025 Bench scenario, backpressure:
- Setup: random inst_ready with 30% high.
- Required: outputs stable while stalled, no instruction skipped or duplicated, count = w*h*tiles.
REQ-026 Bench scenario, strides:
- Setup: stride_x=2, stride_y=3, fw=10, out 2x2.
- Required: fbase offsets 0, 2, 30, 32.
REQ-027 Bench scenario, config error:
- Setup: kh=0.
- Required: no inst_valid, conv_complete 2 cycles after accept, cfg_err=1. It clears on the next good command.
REQ-028 Bench scenarios, abort and reset:
- Abort after the 2nd handshake: IDLE next cycle, no conv_complete, a new command runs correctly.
- rst pulse mid-EXEC: all outputs 0 immediately.

Source files
------------

// File: rtl/tile_instgen.sv
// tile_instgen
//   Turns one CSR convolution command into a stream of per-tile instructions
//   for the decoder. The output plane is walked with the channel tile t
//   innermost, then ox, then oy. All address terms are accumulated with adders.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   csr_*               command handshake (csr_ready high only in IDLE), abort
//   *_baseaddr          SOC byte addresses of the feature, kernel and output buffers
//   feature_*, kernel_*,
//   stride_*, output_*  shape fields
//   has_bias, has_relu  flags copied to every instruction
//   inst_*              instruction stream (valid/ready handshake)
//   conv_complete       one-cycle pulse after the last instruction
//   cfg_err             sticky flag for a zero-sized command; clears on the next accept
module tile_instgen #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int FRAM_AW = 14,
    parameter int KRAM_AW = 12,
    parameter int TILE_CH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_valid,
    output logic               csr_ready,
    input  logic               csr_abort,
    input  logic [ADDR_W-1:0]  feature_baseaddr,
    input  logic [ADDR_W-1:0]  kernel_baseaddr,
    input  logic [ADDR_W-1:0]  output_baseaddr,
    input  logic [DATA_W-1:0]  feature_width,
    input  logic [DATA_W-1:0]  feature_chin,
    input  logic [DATA_W-1:0]  feature_chout,
    input  logic [DATA_W-1:0]  kernel_sizeh,
    input  logic [DATA_W-1:0]  kernel_sizew,
    input  logic [DATA_W-1:0]  stride_x,
    input  logic [DATA_W-1:0]  stride_y,
    input  logic [DATA_W-1:0]  output_width,
    input  logic [DATA_W-1:0]  output_height,
    input  logic               has_bias,
    input  logic               has_relu,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [FRAM_AW-1:0] inst_fbase,
    output logic [KRAM_AW-1:0] inst_kbase,
    output logic [FRAM_AW-1:0] inst_wbbase,
    output logic [DATA_W-1:0]  inst_wb_ch_offset,
    output logic [DATA_W-1:0]  inst_chout,
    output logic [DATA_W-1:0]  inst_chin,
    output logic [DATA_W-1:0]  inst_fwidth,
    output logic [DATA_W-1:0]  inst_ksizeh,
    output logic [DATA_W-1:0]  inst_ksizew,
    output logic               inst_has_bias,
    output logic               inst_has_relu,
    output logic               inst_last,
    output logic               conv_complete,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    // Captured command
    logic [FRAM_AW-1:0] r_fbase_w, r_obase_w;
    logic [KRAM_AW-1:0] r_kbase_w;
    logic [DATA_W-1:0]  r_fwidth, r_chin, r_chout, r_kh, r_kw;
    logic [DATA_W-1:0]  r_sx, r_sy, r_ow, r_oh;
    logic               r_has_bias, r_has_relu, r_cfg_err;

    // Derived in INIT
    logic [DATA_W-1:0]  r_num_tiles, r_plane;
    logic [KRAM_AW-1:0] r_ktile;
    logic [FRAM_AW-1:0] r_row_step, r_tile_step;

    // Loop counters and incremental address accumulators
    logic [DATA_W-1:0]  r_t, r_ox, r_oy, r_ch_rem;
    logic [FRAM_AW-1:0] r_row_fbase, r_fbase, r_wb_pix, r_wb_toff;
    logic [KRAM_AW-1:0] r_kbase;

    logic               w_bad, w_t_wrap, w_ox_wrap, w_oy_wrap, w_last;
    logic [DATA_W:0]    w_nt_sum;
    logic [FRAM_AW-1:0] w_row_next;
    logic               w_unused_addr;

    // Only the word-address slice of each byte address is kept
    assign w_unused_addr = ^{feature_baseaddr, kernel_baseaddr, output_baseaddr};

    assign w_bad = (r_ow == '0) | (r_oh == '0) | (r_chout == '0) | (r_kh == '0) |
                   (r_kw == '0) | (r_sx == '0) | (r_sy == '0);

    assign w_t_wrap   = (r_t  == r_num_tiles - DATA_W'(1));
    assign w_ox_wrap  = (r_ox == r_ow - DATA_W'(1));
    assign w_oy_wrap  = (r_oy == r_oh - DATA_W'(1));
    assign w_last     = w_t_wrap & w_ox_wrap & w_oy_wrap;
    assign w_nt_sum   = {1'b0, r_chout} + (DATA_W+1)'(TILE_CH - 1);
    assign w_row_next = r_row_fbase + r_row_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        csr_ready     = 1'b0;
        inst_valid    = 1'b0;
        conv_complete = 1'b0;
        case (r_state)
            S_IDLE: begin
                csr_ready = 1'b1;
                if (csr_valid) w_state_nxt = S_INIT;
            end
            S_INIT: begin
                if (csr_abort)  w_state_nxt = S_IDLE;
                else if (w_bad) w_state_nxt = S_DONE;
                else            w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                inst_valid = 1'b1;
                if (csr_abort)                  w_state_nxt = S_IDLE;
                else if (inst_ready && w_last)  w_state_nxt = S_DONE;
            end
            S_DONE: begin
                conv_complete = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fbase_w   <= '0;
            r_obase_w   <= '0;
            r_kbase_w   <= '0;
            r_fwidth    <= '0;
            r_chin      <= '0;
            r_chout     <= '0;
            r_kh        <= '0;
            r_kw        <= '0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_ow        <= '0;
            r_oh        <= '0;
            r_has_bias  <= 1'b0;
            r_has_relu  <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_num_tiles <= '0;
            r_plane     <= '0;
            r_ktile     <= '0;
            r_row_step  <= '0;
            r_tile_step <= '0;
            r_t         <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_ch_rem    <= '0;
            r_row_fbase <= '0;
            r_fbase     <= '0;
            r_wb_pix    <= '0;
            r_wb_toff   <= '0;
            r_kbase     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (csr_valid) begin
                        r_fbase_w  <= feature_baseaddr[2 +: FRAM_AW];
                        r_kbase_w  <= kernel_baseaddr[2 +: KRAM_AW];
                        r_obase_w  <= output_baseaddr[2 +: FRAM_AW];
                        r_fwidth   <= feature_width;
                        r_chin     <= feature_chin;
                        r_chout    <= feature_chout;
                        r_kh       <= kernel_sizeh;
                        r_kw       <= kernel_sizew;
                        r_sx       <= stride_x;
                        r_sy       <= stride_y;
                        r_ow       <= output_width;
                        r_oh       <= output_height;
                        r_has_bias <= has_bias;
                        r_has_relu <= has_relu;
                        r_cfg_err  <= 1'b0;
                    end
                end
                S_INIT: begin
                    r_t  <= '0;
                    r_ox <= '0;
                    r_oy <= '0;
                    if (!csr_abort) begin
                        // One-time products; the walk itself only adds these steps
                        r_num_tiles <= DATA_W'(w_nt_sum / (DATA_W+1)'(TILE_CH));
                        r_ktile     <= KRAM_AW'(DATA_W'(TILE_CH) * r_chin * r_kh * r_kw);
                        r_plane     <= r_ow * r_oh;
                        r_row_step  <= FRAM_AW'(r_sy * r_fwidth);
                        r_tile_step <= FRAM_AW'(DATA_W'(TILE_CH) * r_ow * r_oh);
                        r_row_fbase <= r_fbase_w;
                        r_fbase     <= r_fbase_w;
                        r_kbase     <= r_kbase_w;
                        r_wb_pix    <= r_obase_w;
                        r_wb_toff   <= '0;
                        r_ch_rem    <= r_chout;
                        if (w_bad) r_cfg_err <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (csr_abort) begin
                        r_t  <= '0;
                        r_ox <= '0;
                        r_oy <= '0;
                    end else if (inst_ready) begin
                        if (!w_t_wrap) begin
                            r_t       <= r_t + DATA_W'(1);
                            r_kbase   <= r_kbase + r_ktile;
                            r_wb_toff <= r_wb_toff + r_tile_step;
                            r_ch_rem  <= r_ch_rem - DATA_W'(TILE_CH);
                        end else begin
                            // Tile loop wraps: restart tile terms, step one output pixel.
                            // oy*ow+ox is the linear pixel index, so it just counts up.
                            r_t       <= '0;
                            r_kbase   <= r_kbase_w;
                            r_wb_toff <= '0;
                            r_ch_rem  <= r_chout;
                            r_wb_pix  <= r_wb_pix + FRAM_AW'(1);
                            if (!w_ox_wrap) begin
                                r_ox    <= r_ox + DATA_W'(1);
                                r_fbase <= r_fbase + r_sx[FRAM_AW-1:0];
                            end else begin
                                r_ox        <= '0;
                                r_oy        <= r_oy + DATA_W'(1);
                                r_row_fbase <= w_row_next;
                                r_fbase     <= w_row_next;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign inst_fbase        = r_fbase;
    assign inst_kbase        = r_kbase;
    assign inst_wbbase       = r_wb_pix + r_wb_toff;
    assign inst_wb_ch_offset = r_plane;
    assign inst_chout        = (r_ch_rem > DATA_W'(TILE_CH)) ? DATA_W'(TILE_CH) : r_ch_rem;
    assign inst_chin         = r_chin;
    assign inst_fwidth       = r_fwidth;
    assign inst_ksizeh       = r_kh;
    assign inst_ksizew       = r_kw;
    assign inst_has_bias     = r_has_bias;
    assign inst_has_relu     = r_has_relu;
    assign inst_last         = (r_state == S_EXEC) & w_last;
    assign cfg_err           = r_cfg_err;

endmodule
